instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Inverse of the opcode/control decode path.
- Accepts field-level instruction descriptors over a valid/ready handshake and encodes them into 32-bit RV32I words for the four supported formats: R, lw, sw, sb.
- Streams the encoded words into instruction memory at word-incrementing addresses.
- Used by the testbench/boot path to load programs into the single-cycle core's instruction memory before releasing the core.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width.
- MAX_WORDS, 256, words per load session; the address window is base_i .. base_i+4*(MAX_WORDS-1).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- start_i  input  1  one-cycle pulse; begins a session (ignored unless IDLE)
- base_i  input  ADDR_W  start byte address, sampled on start_i; bits [1:0] ignored
- len_i  input  9  number of words to load, sampled on start_i; 1..MAX_WORDS
- valid_i  input  1  descriptor valid
- ready_o  output  1  descriptor accepted when valid_i&&ready_o
- fmt_i  input  2  0=R, 1=lw, 2=sw, 3=sb
- rd_i  input  5  destination register
- rs1_i  input  5  source register 1
- rs2_i  input  5  source register 2
- funct3_i  input  3  funct3 field
- funct7_i  input  7  funct7 field (R only)
- imm_i  input  13  signed immediate; lw/sw use [11:0], sb uses [12:1]
- imem_we_o  output  1  instruction-memory write strobe
- imem_addr_o  output  ADDR_W  byte address of write
- imem_wdata_o  output  32  encoded word
- busy_o  output  1  session in progress
- done_o  output  1  one-cycle pulse when the session ends
- err_o  output  1  sticky; a descriptor was rejected in this session

Behaviour:
- Reset (async, rst_ni=0): state IDLE; ready_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, busy_o=0, done_o=0, err_o=0; word counter=0.
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - start_i with 1<=len_i<=MAX_WORDS -> ACCEPT; latch base, len; clear counter and err_o.
  - start_i with len_i=0 or len_i>MAX_WORDS -> DONE with err_o=1.
- ACCEPT:
  - ready_o=1.
  - On handshake, encode combinationally and register the word and address -> WRITE.
- WRITE:
  - imem_we_o=1 for exactly one cycle; ready_o=0; counter increments.
  - If the counter now equals len -> DONE, else -> ACCEPT.
  - Throughput: 1 word per 2 cycles. Latency: handshake cycle +1 = write strobe.
- DONE: done_o=1 for one cycle -> IDLE. busy_o=1 in ACCEPT, WRITE and DONE.
- Address: imem_addr_o = base + 4*counter, computed modulo 2^ADDR_W (wrap-around allowed, no error).
- Encoding, bit-exact:
  - R: {funct7, rs2, rs1, funct3, rd, 0110011}
  - lw: {imm[11:0], rs1, funct3, rd, 0000011}
  - sw: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}
  - sb: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}
  - Unused descriptor fields are don't-care and do not affect the output.
- Boundaries:
  - start_i while busy: ignored.
  - valid_i outside ACCEPT: not accepted, no side effects.
  - valid_i may be held across WRITE; the descriptor is accepted on the next ACCEPT cycle.
  - Reset mid-session: immediate return to IDLE; no further writes; partially written memory is left as-is.
- imem_wdata_o and imem_addr_o hold their last values outside WRITE.

Optional Feature:
- Macro IMM_CHECK_EN.
- Defined:
  - In ACCEPT, a handshake with an illegal descriptor is consumed, no write occurs, the counter does not advance, err_o=1, state stays ACCEPT.
  - Illegal means: lw/sw with imm_i[12] != imm_i[11] (out of 12-bit range); sb with imm_i[0]=1 (odd offset).
- Not defined: no checking; every descriptor is encoded and written; the upper and low immediate bits are simply truncated per format.

Test Plan:
- Reset: hold rst_ni=0 mid-WRITE -> all outputs 0 asynchronously; after release, state IDLE and ready_o=0.
- start base=0x000, len=1; R funct7=0, rs2=2, rs1=1, funct3=0, rd=3 -> single write, addr 0x000, data 0x002081B3, done_o pulse 1 cycle after the write.
- start base=0x010, len=3; lw x5,8(x2); sw x6,12(x2); beq x1,x2,-8 (imm=0x1FF8) -> writes 0x00812283@0x010, 0x00612623@0x014, 0xFE208CE3@0x018; err_o=0.
- Backpressure: valid_i held high continuously, len=4 -> ready_o toggles 1,0; exactly 4 strobes, each in the cycle after a handshake; start_i pulsed mid-session is ignored.
- Wrap: ADDR_W=10, base=0x3FC, len=2 -> writes at 0x3FC then 0x000. Separately, start len=0 -> done_o pulse, err_o=1, no writes.
- IMM_CHECK_EN: sb with imm=0x0005 -> no write, err_o=1, still ACCEPT; the following valid sb imm=0x0004 writes at the unchanged address.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Encodes R/lw/sw/sb field descriptors into RV32I words and streams them into
// instruction memory. Define IMM_CHECK_EN to reject out-of-range immediates.
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [8:0]        len_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        fmt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [12:0]       imm_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [1:0] FMT_R  = 2'd0;
  localparam logic [1:0] FMT_LW = 2'd1;
  localparam logic [1:0] FMT_SW = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic [8:0]        r_len;
  logic [8:0]        r_cnt;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic              w_len_ok;
  logic              w_illegal;
  logic [8:0]        w_cnt_next;
  logic [ADDR_W-1:0] w_off;
  logic [31:0]       w_word;

  function automatic logic [31:0] encode(
    input logic [1:0]  fmt,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [12:0] imm
  );
    logic [31:0] word;
    case (fmt)
      FMT_R:   word = {f7, rs2, rs1, f3, rd, 7'b0110011};
      FMT_LW:  word = {imm[11:0], rs1, f3, rd, 7'b0000011};
      FMT_SW:  word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      default: word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endcase
    return word;
  endfunction

`ifdef IMM_CHECK_EN
  // lw/sw need a value representable in 12 signed bits; branches must be even
  function automatic logic imm_illegal(input logic [1:0] fmt, input logic [12:0] imm);
    logic bad;
    case (fmt)
      FMT_LW, FMT_SW: bad = (imm[12] != imm[11]);
      FMT_R:          bad = 1'b0;
      default:        bad = imm[0];
    endcase
    return bad;
  endfunction

  assign w_illegal = imm_illegal(fmt_i, imm_i);
`else
  assign w_illegal = 1'b0;
`endif

  assign w_len_ok   = (len_i != 9'd0) && (32'(len_i) <= 32'(MAX_WORDS));
  assign w_cnt_next = r_cnt + 9'd1;
  assign w_off      = ADDR_W'({r_cnt, 2'b00});
  assign w_word     = encode(fmt_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (w_len_ok) begin
              r_state <= S_ACCEPT;
              r_base  <= {base_i[ADDR_W-1:2], 2'b00};
              r_len   <= len_i;
              r_cnt   <= '0;
              r_err   <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_err   <= 1'b1;
            end
          end
        end
        S_ACCEPT: begin
          if (valid_i) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_wdata <= w_word;
              r_addr  <= r_base + w_off;
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_cnt   <= w_cnt_next;
          r_state <= (w_cnt_next == r_len) ? S_DONE : S_ACCEPT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o      = (r_state == S_ACCEPT);
  assign imem_we_o    = (r_state == S_WRITE);
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_DONE);
  assign err_o        = r_err;
  assign imem_addr_o  = r_addr;
  assign imem_wdata_o = r_wdata;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: known-word table, corner-case
// sequences and randomized sessions checked against a field-packing model.
module tb_instr_encoder_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [AW-1:0] base_i;
  logic [8:0]    len_i;
  logic          valid_i;
  logic          ready_o;
  logic [1:0]    fmt_i;
  logic [4:0]    rd_i, rs1_i, rs2_i;
  logic [2:0]    funct3_i;
  logic [6:0]    funct7_i;
  logic [12:0]   imm_i;
  logic          imem_we_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o;
  logic          busy_o, done_o, err_o;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(AW), .MAX_WORDS(256)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .base_i(base_i), .len_i(len_i),
    .valid_i(valid_i), .ready_o(ready_o), .fmt_i(fmt_i), .rd_i(rd_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct {
    logic [1:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [12:0] imm;
    logic [31:0] word;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;

  always @(negedge clk) if (imem_we_o === 1'b1) n_wr++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, want);
    end
  endtask

  // Packs fields with plain shifts from the instruction-format definitions
  function automatic logic [31:0] model_enc(input vec_t v);
    int unsigned imm, w;
    imm = 32'(v.imm);
    w = (32'(v.f3) << 12) | (32'(v.rs1) << 15);
    case (v.fmt)
      2'd0: w |= (32'(v.f7) << 25) | (32'(v.rs2) << 20) | (32'(v.rd) << 7) | 32'h33;
      2'd1: w |= ((imm & 32'hFFF) << 20) | (32'(v.rd) << 7) | 32'h03;
      2'd2: w |= (((imm >> 5) & 32'h7F) << 25) | (32'(v.rs2) << 20)
               | ((imm & 32'h1F) << 7) | 32'h23;
      default: w |= (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                  | (32'(v.rs2) << 20) | (((imm >> 1) & 32'hF) << 8)
                  | (((imm >> 11) & 1) << 7) | 32'h63;
    endcase
    return w;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.fmt = 2'($urandom_range(0, 3));
    v.rd  = 5'($urandom);
    v.rs1 = 5'($urandom);
    v.rs2 = 5'($urandom);
    v.f3  = 3'($urandom);
    v.f7  = 7'($urandom);
    v.imm = 13'($urandom);
`ifdef IMM_CHECK_EN
    if (v.fmt == 2'd1 || v.fmt == 2'd2) v.imm[12] = v.imm[11];
    if (v.fmt == 2'd3) v.imm[0] = 1'b0;
`endif
    v.word = model_enc(v);
    return v;
  endfunction

  function automatic vec_t mk(input logic [1:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [12:0] imm, input logic [31:0] word);
    vec_t v;
    v.fmt = fmt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.word = word;
    return v;
  endfunction

  task automatic start_sess(input logic [AW-1:0] b, input logic [8:0] l);
    start_i = 1'b1; base_i = b; len_i = l;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Waits for ready, lets the handshake happen, then checks the write strobe
  task automatic send(input vec_t v, input logic [AW-1:0] ea, input bit hold);
    int n;
    fmt_i = v.fmt; rd_i = v.rd; rs1_i = v.rs1; rs2_i = v.rs2;
    funct3_i = v.f3; funct7_i = v.f7; imm_i = v.imm;
    valid_i = 1'b1;
    n = 0;
    while (ready_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      start_i = 1'b0;
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=%b expected=1", ready_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    chk("we", 32'(imem_we_o), 32'd1);
    chk("addr", 32'(imem_addr_o), 32'(ea));
    chk("wdata", imem_wdata_o, v.word);
    chk("ready_in_write", 32'(ready_o), 32'd0);
    if (!hold) valid_i = 1'b0;
  endtask

  task automatic end_sess();
    @(negedge clk);
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("busy_done", 32'(busy_o), 32'd1);
    @(negedge clk);
    chk("done_low", 32'(done_o), 32'd0);
    chk("busy_idle", 32'(busy_o), 32'd0);
    chk("ready_idle", 32'(ready_o), 32'd0);
  endtask

  vec_t tbl [6];

  initial begin
    int w0, ln;
    logic [AW-1:0] b;
    vec_t v;

    tbl[0] = mk(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 13'h0000, 32'h002081B3);
    tbl[1] = mk(2'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 13'h0008, 32'h00812283);
    tbl[2] = mk(2'd2, 5'd0, 5'd2, 5'd6, 3'd2, 7'h00, 13'h000C, 32'h00612623);
    tbl[3] = mk(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 13'h1FF8, 32'hFE208CE3);
    tbl[4] = mk(2'd0, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 13'h0000, 32'h409403B3);
    tbl[5] = mk(2'd1, 5'd1, 5'd2, 5'd0, 3'd2, 7'h00, 13'h1FFC, 32'hFFC12083);

    rst_ni = 1'b0; start_i = 1'b0; base_i = '0; len_i = '0; valid_i = 1'b0;
    fmt_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; funct3_i = '0; funct7_i = '0; imm_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_we", 32'(imem_we_o), 32'd0);
    chk("rst_addr", 32'(imem_addr_o), 32'd0);
    chk("rst_wdata", imem_wdata_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    w0 = n_wr;
    start_sess(10'h000, 9'd1);
    send(tbl[0], 10'h000, 1'b0);
    end_sess();
    chk("single_writes", 32'(n_wr - w0), 32'd1);

    w0 = n_wr;
    start_sess(10'h010, 9'd5);
    for (int i = 1; i < 6; i++) send(tbl[i], AW'(10'h010 + 4 * (i - 1)), 1'b0);
    end_sess();
    chk("table_err", 32'(err_o), 32'd0);
    chk("table_writes", 32'(n_wr - w0), 32'd5);

    // valid held high across writes, DONE and idle; a stray start mid-session
    w0 = n_wr;
    start_sess(10'h080, 9'd4);
    for (int i = 0; i < 4; i++) begin
      v = rand_vec();
      send(v, AW'(10'h080 + 4 * i), 1'b1);
      if (i == 1) begin start_i = 1'b1; base_i = 10'h200; len_i = 9'd1; end
    end
    end_sess();
    @(negedge clk);
    valid_i = 1'b0;
    chk("bp_writes", 32'(n_wr - w0), 32'd4);
    chk("bp_addr_hold", 32'(imem_addr_o), 32'h08C);

    w0 = n_wr;
    start_sess(10'h3FD, 9'd2);
    send(tbl[4], 10'h3FC, 1'b0);
    send(tbl[0], 10'h000, 1'b0);
    end_sess();
    chk("wrap_writes", 32'(n_wr - w0), 32'd2);

    w0 = n_wr;
    start_sess(10'h000, 9'd0);
    chk("len0_done", 32'(done_o), 32'd1);
    chk("len0_err", 32'(err_o), 32'd1);
    @(negedge clk);
    chk("len0_idle", 32'(busy_o), 32'd0);
    chk("len0_sticky", 32'(err_o), 32'd1);
    start_sess(10'h000, 9'd257);
    chk("len257_done", 32'(done_o), 32'd1);
    chk("len257_err", 32'(err_o), 32'd1);
    @(negedge clk);
    chk("badlen_writes", 32'(n_wr - w0), 32'd0);
    start_sess(10'h020, 9'd1);
    chk("err_cleared", 32'(err_o), 32'd0);
    send(tbl[5], 10'h020, 1'b0);
    end_sess();

    w0 = n_wr;
    start_sess(10'h040, 9'd3);
    send(tbl[1], 10'h040, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_we", 32'(imem_we_o), 32'd0);
    chk("arst_addr", 32'(imem_addr_o), 32'd0);
    chk("arst_wdata", imem_wdata_o, 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    valid_i = 1'b1;
    repeat (4) @(negedge clk);
    valid_i = 1'b0;
    chk("post_rst_ready", 32'(ready_o), 32'd0);
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    chk("post_rst_writes", 32'(n_wr - w0), 32'd1);

`ifdef IMM_CHECK_EN
    w0 = n_wr;
    start_sess(10'h040, 9'd1);
    v = mk(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 13'h0005, 32'h0);
    fmt_i = v.fmt; rs1_i = v.rs1; rs2_i = v.rs2; funct3_i = v.f3; imm_i = v.imm;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    chk("ill_no_we", 32'(imem_we_o), 32'd0);
    chk("ill_err", 32'(err_o), 32'd1);
    chk("ill_ready", 32'(ready_o), 32'd1);
    v.imm = 13'h0004;
    v.word = model_enc(v);
    send(v, 10'h040, 1'b0);
    end_sess();
    chk("ill_writes", 32'(n_wr - w0), 32'd1);
`endif

    for (int s = 0; s < 20; s++) begin
      b  = AW'($urandom);
      ln = $urandom_range(1, 6);
      w0 = n_wr;
      start_sess(b, 9'(ln));
      for (int i = 0; i < ln; i++) begin
        v = rand_vec();
        send(v, AW'((32'(b) & ~32'h3) + 4 * i), 1'b0);
      end
      end_sess();
      chk("rand_writes", 32'(n_wr - w0), 32'(ln));
      chk("rand_err", 32'(err_o), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
